// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves one RV32I conditional branch at a time. A request is captured in
//   IDLE, evaluated for one cycle in EVAL, presented in RESP until the consumer
//   accepts it and, for taken branches, followed by FLUSH_CYCLES cycles of flush.
//
//   Optional build macro: BRANCH_STATS_EN enables the saturating taken/not-taken
//   counters; without it taken_cnt and nt_cnt are constant zero.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : branch request present
//   req_ready  : block can accept a request (IDLE only)
//   funct3     : B-type branch condition
//   eq/lt/ltu  : operand comparison flags (equal, signed less, unsigned less)
//   pc, imm    : branch address and sign-extended offset
//   resp_valid : result valid (RESP only)
//   resp_ready : consumer accepts the result
//   taken      : branch taken
//   target     : pc + imm, meaningful only while taken = 1
//   err        : illegal funct3 or misaligned taken target
//   flush      : pipeline flush request (FLUSH only)
//   taken_cnt  : taken-branch count
//   nt_cnt     : not-taken-branch count (error responses excluded)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic        eq,
  input  logic        lt,
  input  logic        ltu,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        taken,
  output logic [31:0] target,
  output logic        err,
  output logic        flush,
  output logic [15:0] taken_cnt,
  output logic [15:0] nt_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP,
    FLUSH
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state, state_nxt;

  logic [2:0]  f3_q;
  logic        eq_q, lt_q, ltu_q;
  logic [31:0] pc_q, imm_q;

  logic        taken_q, err_q;
  logic [31:0] target_q;
  logic [2:0]  cnt_q;

  logic        hs_req, hs_resp;
  logic        eval_taken, eval_err;
  logic [31:0] eval_target;

  // req_ready is gated by rst_n so it reads 0 while reset is held.
  assign req_ready  = rst_n & (state == IDLE);
  assign hs_req     = req_valid & req_ready;
  assign hs_resp    = (state == RESP) & resp_ready;

  assign resp_valid = (state == RESP);
  assign flush      = (state == FLUSH);
  assign taken      = taken_q;
  assign target     = target_q;
  assign err        = err_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs_req) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = taken_q ? FLUSH : IDLE;
      FLUSH:   if (cnt_q <= 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch condition evaluation on the captured request
  // ---------------------------------------------------------------------------
  always_comb begin
    eval_taken  = 1'b0;
    eval_err    = 1'b0;
    eval_target = pc_q + imm_q;   // carry-out intentionally dropped
    case (f3_q)
      3'b000:  eval_taken = eq_q;
      3'b001:  eval_taken = ~eq_q;
      3'b100:  eval_taken = lt_q;
      3'b101:  eval_taken = ~lt_q;
      3'b110:  eval_taken = ltu_q;
      3'b111:  eval_taken = ~ltu_q;
      default: eval_err   = 1'b1;
    endcase
    // A misaligned taken target is flagged but the branch is still reported taken.
    if (eval_taken && (eval_target[1:0] != 2'b00)) eval_err = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q     <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (hs_req) begin
        f3_q  <= funct3;
        eq_q  <= eq;
        lt_q  <= lt;
        ltu_q <= ltu;
        pc_q  <= pc;
        imm_q <= imm;
      end
      if (state == EVAL) begin
        taken_q  <= eval_taken;
        err_q    <= eval_err;
        target_q <= eval_target;
      end
      if (hs_resp && taken_q)  cnt_q <= FLUSH_LOAD;
      else if (state == FLUSH) cnt_q <= cnt_q - 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional branch statistics
  // ---------------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, nt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
    end else if (hs_resp) begin
      if (taken_q) begin
        if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else if (!err_q) begin
        if (nt_cnt_q != '1) nt_cnt_q <= nt_cnt_q + 16'd1;
      end
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign nt_cnt    = nt_cnt_q;
`else
  assign taken_cnt = '0;
  assign nt_cnt    = '0;
`endif

endmodule
